fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences instruction fetch for the core front end.
- Owns the fetch PC and issues line-sized read requests on the system bus.
- Collects the 64-bit response beats into a line buffer, then hands 32-bit instructions to the decoder one at a time over a valid/ready handshake.
- Handles branch redirects, including discarding a bus transaction that is already in flight.

Parameters:
- BUS_DATA_WIDTH, 64, width of one bus response beat; two instructions per beat.
- ADDR_WIDTH, 64, width of PC and bus address.
- BEATS, 8, beats per line; line = BEATS*8 bytes = 64 B, 16 instructions.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- fetch_en  in  1  permission to start new line fetches.
- start_pc  in  ADDR_WIDTH  PC loaded while reset_n=0.
- bus_req  out  1  line read request.
- bus_reqaddr  out  ADDR_WIDTH  line-aligned request address.
- bus_reqack  in  1  request accepted.
- bus_resp  in  BUS_DATA_WIDTH  response beat.
- bus_respvalid  in  1  beat valid.
- bus_respack  out  1  beat consumed.
- ins  out  32  instruction to decoder.
- ins_pc  out  ADDR_WIDTH  address of ins.
- ins_valid  out  1  ins/ins_pc valid.
- ins_ready  in  1  decoder accepts.
- redirect_valid  in  1  branch redirect.
- redirect_pc  in  ADDR_WIDTH  redirect target.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=IDLE, pc=start_pc with bits[1:0] forced to 0.
  - beat_cnt=0, slot=0, flush flag clear.
  - Outputs bus_req, bus_respack, ins_valid and busy are 0; bus_reqaddr, ins and ins_pc are 0.
  - Reset mid-transaction abandons the transaction; the bus is reset with the core.
- States: IDLE, REQ, RECV, ISSUE, FLUSH.
- IDLE:
  - fetch_en=1 -> REQ next cycle.
  - bus_req is asserted the cycle after fetch_en is seen.
- REQ:
  - bus_req=1, bus_reqaddr = pc with bits[5:0] cleared.
  - Address is held stable until bus_reqack.
  - On bus_reqack -> RECV, beat_cnt=0.
- RECV:
  - bus_respack = bus_respvalid in the same cycle (combinational).
  - Each valid beat is written to buf[beat_cnt], then beat_cnt++.
  - On beat BEATS-1 -> ISSUE with slot = pc[5:2].
- ISSUE:
  - ins_valid=1.
  - ins = buf[slot>>1][31:0] if slot is even, else buf[slot>>1][63:32] (low half first).
  - ins_pc = pc.
  - On ins_valid & ins_ready: pc += 4, slot++.
  - On the handshake at slot 15: fetch_en=1 -> REQ (next line, pc already advanced); fetch_en=0 -> IDLE.
  - While ins_ready=0, ins and ins_pc are held stable.
- fetch_en is sampled only in IDLE and at the end of ISSUE; deasserting it never aborts an outstanding transaction.
- Redirect (redirect_valid=1 at posedge):
  - In every state, pc <= redirect_pc with bits[1:0] cleared.
  - IDLE: -> REQ if fetch_en, else stay.
  - ISSUE: ins_valid drops next cycle; -> REQ if fetch_en, else IDLE.
    - If ins_ready is also high that cycle, the instruction counts as consumed, but pc takes the redirect value (no +4).
  - REQ without bus_reqack: -> REQ; bus_reqaddr updates next cycle.
  - REQ with bus_reqack in the same cycle: -> FLUSH, beat_cnt=0.
  - RECV: -> FLUSH; beat_cnt is preserved.
    - A beat valid in the redirect cycle is acked and counted.
  - FLUSH: stays in FLUSH; pc is updated.
- FLUSH:
  - Acks and discards every remaining beat; ins_valid=0.
  - After beat BEATS-1: -> REQ if fetch_en, else IDLE.
- Counters: beat_cnt is $clog2(BEATS) bits and slot is 4 bits; neither wraps outside the transitions defined above.
- pc: increments modulo 2^ADDR_WIDTH.

Test Plan:
1. Basic line fetch:
   - Stimulus: start_pc=0x1000, fetch_en=1 from reset release; bus_reqack on the first cycle; beat k = {32'(2k+1), 32'(2k)}.
   - Response: bus_req one cycle after reset release, bus_reqaddr=0x1000. After 8 beats, ins = 0..15 in order with ins_pc 0x1000..0x103C. Next request is bus_reqaddr=0x1040.
2. Mid-line start:
   - Stimulus: start_pc=0x1018.
   - Response: request 0x1000; first ins=6 (beat 3 low half), ins_pc=0x1018; exactly 10 instructions issued, last ins_pc=0x103C.
3. Backpressure:
   - Stimulus: ins_ready=0 for 5 cycles at slot 3, and bus_respvalid gapped 2 cycles between beats.
   - Response: ins=3 and ins_pc held for all 5 cycles; no duplicate or skipped instruction; all beats stored correctly.
4. Redirect during RECV:
   - Stimulus: after beat 3, redirect_pc=0x2006.
   - Response: beats 4-7 are acked with ins_valid=0. Next bus_reqaddr=0x2000; first ins is beat 0 high half with ins_pc=0x2004.
5. Simultaneous redirect and handshake:
   - Stimulus: in ISSUE at ins_pc=0x1008, assert ins_ready and redirect_pc=0x3000 in the same cycle.
   - Response: 0x1008 is consumed once; no 0x100C is issued; next request is 0x3000.
6. Reset mid-operation and fetch_en=0:
   - Stimulus: reset_n=0 during RECV.
   - Response: next cycle all outputs are 0, state=IDLE, pc=start_pc.
   - Stimulus: then fetch_en=0 at the end of ISSUE.
   - Response: IDLE, busy=0, no bus_req.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Front-end fetch sequencer: line requests, beat collection and
// one-at-a-time instruction issue with branch redirect handling.
module fetch_ctrl #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH     = 64,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      fetch_en,
    input  logic [ADDR_WIDTH-1:0]     start_pc,
    output logic                      bus_req,
    output logic [ADDR_WIDTH-1:0]     bus_reqaddr,
    input  logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic                      bus_respvalid,
    output logic                      bus_respack,
    output logic [31:0]               ins,
    output logic [ADDR_WIDTH-1:0]     ins_pc,
    output logic                      ins_valid,
    input  logic                      ins_ready,
    input  logic                      redirect_valid,
    input  logic [ADDR_WIDTH-1:0]     redirect_pc,
    output logic                      busy
);

    localparam int CW = $clog2(BEATS);
    localparam int LW = $clog2(BEATS * 8);
    localparam int SW = LW - 2;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(BEATS * 8 - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_ISSUE,
        S_FLUSH
    } state_t;

    state_t                    state_q;
    logic [ADDR_WIDTH-1:0]     pc_q;
    logic [CW-1:0]             beat_q;
    logic [SW-1:0]             slot_q;
    logic [BUS_DATA_WIDTH-1:0] line_q [BEATS];

    logic   beat_last;
    logic   slot_last;
    state_t done_st;
    logic [31:0] word;

    assign beat_last = (beat_q == LAST_BEAT);
    assign slot_last = &slot_q;
    assign done_st   = fetch_en ? S_REQ : S_IDLE;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= start_pc & WORD_MASK;
            beat_q  <= '0;
            slot_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (fetch_en) state_q <= S_REQ;
                end
                S_REQ: begin
                    if (bus_reqack) begin
                        beat_q  <= '0;
                        state_q <= redirect_valid ? S_FLUSH : S_RECV;
                    end
                end
                S_RECV: begin
                    if (bus_respvalid) begin
                        line_q[beat_q] <= bus_resp;
                        beat_q         <= beat_q + CW'(1);
                    end
                    // a redirect on the final beat has nothing left to drain
                    if (bus_respvalid && beat_last) begin
                        slot_q  <= pc_q[LW-1:2];
                        state_q <= redirect_valid ? done_st : S_ISSUE;
                    end else if (redirect_valid) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_ISSUE: begin
                    if (ins_ready) begin
                        slot_q <= slot_q + SW'(1);
                        pc_q   <= pc_q + ADDR_WIDTH'(4);
                    end
                    if (redirect_valid || (ins_ready && slot_last)) begin
                        state_q <= done_st;
                    end
                end
                S_FLUSH: begin
                    if (bus_respvalid) begin
                        beat_q <= beat_q + CW'(1);
                        if (beat_last) state_q <= done_st;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (redirect_valid) pc_q <= redirect_pc & WORD_MASK;
        end
    end

    assign word = slot_q[0] ? line_q[slot_q[SW-1:1]][63:32]
                            : line_q[slot_q[SW-1:1]][31:0];

    assign bus_req     = (state_q == S_REQ);
    assign bus_reqaddr = bus_req ? (pc_q & LINE_MASK) : '0;
    assign bus_respack = bus_respvalid &&
                         (state_q == S_RECV || state_q == S_FLUSH);
    assign ins_valid   = (state_q == S_ISSUE);
    assign ins         = ins_valid ? word : 32'h0;
    assign ins_pc      = ins_valid ? pc_q : '0;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: bus slave, decoder and an
// instruction-stream reference model driven by the fetch rules.
module tb_fetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic [63:0] start_pc = 64'h0;
    logic        bus_req;
    logic [63:0] bus_reqaddr;
    logic        bus_reqack = 1'b0;
    logic [63:0] bus_resp = 64'h0;
    logic        bus_respvalid = 1'b0;
    logic        bus_respack;
    logic [31:0] ins;
    logic [63:0] ins_pc;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        busy;

    fetch_ctrl dut (
        .clk(clk),
        .reset_n(reset_n),
        .fetch_en(fetch_en),
        .start_pc(start_pc),
        .bus_req(bus_req),
        .bus_reqaddr(bus_reqaddr),
        .bus_reqack(bus_reqack),
        .bus_resp(bus_resp),
        .bus_respvalid(bus_respvalid),
        .bus_respack(bus_respack),
        .ins(ins),
        .ins_pc(ins_pc),
        .ins_valid(ins_valid),
        .ins_ready(ins_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .busy(busy)
    );

    localparam logic [63:0] LMASK = ~64'h3F;

    int total = 0;
    int bad = 0;

    int ack_pct = 100, resp_pct = 100, rdy_pct = 100;
    int redir_pm = 0, fe_pct = 100;
    bit gap_mode = 0, hold_armed = 0, in_hold = 0;
    bit hook4 = 0, hook5 = 0, hook6 = 0;
    int hold_left = 0, gap_ctr = 0, rst_cycles = 0;

    logic [63:0] exp_pc = 64'h0, sl_addr = 64'h0, last_ack_addr = 64'h0;
    bit sl_active = 0, taint = 0, line_ok = 0;
    int sl_beats = 0, hs_cnt = 0, line_hs = 0, last_line_hs = 0, ack_cnt = 0;
    bit rst_prev = 1, rst_prev2 = 1, fe_prev = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'(a >> 2) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [63:0] pick_target();
        logic [63:0] t;
        case ($urandom_range(3))
            0: t = 64'h1000 + 64'($urandom_range(4095));
            1: t = {$urandom, $urandom};
            2: t = 64'hFFFF_FFFF_FFFF_FFC0 + 64'($urandom_range(63));
            default: t = 64'h2000 + 64'($urandom_range(255));
        endcase
        return t;
    endfunction

    task automatic drive();
        if (hook6 && sl_active && sl_beats == 2) begin
            hook6 = 0;
            rst_cycles = 1;
        end
        reset_n = (rst_cycles == 0);
        if (rst_cycles > 0) rst_cycles--;
        fetch_en = ($urandom_range(99) < fe_pct);
        bus_reqack = 0;
        bus_respvalid = 0;
        redirect_valid = 0;
        redirect_pc = pick_target();
        in_hold = 0;
        ins_ready = ($urandom_range(99) < rdy_pct);
        bus_resp = {mem_word(sl_addr + 64'(sl_beats * 8 + 4)),
                    mem_word(sl_addr + 64'(sl_beats * 8))};
        if (!reset_n) return;
        bus_reqack = bus_req && ($urandom_range(99) < ack_pct);
        if (sl_active) begin
            if (gap_mode) begin
                bus_respvalid = (gap_ctr == 2);
                gap_ctr = (gap_ctr == 2) ? 0 : gap_ctr + 1;
            end else begin
                bus_respvalid = ($urandom_range(99) < resp_pct);
            end
        end
        redirect_valid = ($urandom_range(999) < redir_pm);
        if (hold_armed && ins_valid && ins_pc[5:2] == 4'd3) begin
            hold_armed = 0;
            hold_left = 5;
        end
        if (hold_left > 0) begin
            hold_left--;
            ins_ready = 0;
            in_hold = 1;
        end
        if (hook4 && sl_active && sl_beats == 4) begin
            hook4 = 0;
            redirect_valid = 1;
            redirect_pc = 64'h2006;
        end
        if (hook5 && ins_valid && ins_pc == 64'h1008) begin
            hook5 = 0;
            ins_ready = 1;
            redirect_valid = 1;
            redirect_pc = 64'h3000;
        end
    endtask

    task automatic observe();
        bit hs;
        if (!rst_prev) begin
            check("rst_req", 64'(bus_req), 64'd0);
            check("rst_addr", bus_reqaddr, 64'd0);
            check("rst_valid", 64'(ins_valid), 64'd0);
            check("rst_ins", 64'(ins), 64'd0);
            check("rst_pc", ins_pc, 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_rack", 64'(bus_respack), 64'd0);
        end else if (!rst_prev2 && fe_prev) begin
            check("rel_req", 64'(bus_req), 64'd1);
            check("rel_addr", bus_reqaddr, exp_pc & LMASK);
        end
        if (!reset_n) begin
            exp_pc = start_pc & ~64'h3;
            sl_active = 0;
            taint = 0;
            line_ok = 0;
            line_hs = 0;
            ack_cnt = 0;
            return;
        end
        check("valid", 64'(ins_valid), 64'(line_ok));
        if (line_ok) begin
            check("ins_pc", ins_pc, exp_pc);
            check("ins", 64'(ins), 64'(mem_word(exp_pc)));
        end
        if (in_hold) begin
            check("hold_pc", ins_pc, 64'h100C);
            check("hold_ins", 64'(ins), 64'(mem_word(64'h100C)));
        end
        if (sl_active || line_ok) check("busy", 64'(busy), 64'd1);
        if (sl_active) check("req_quiet", 64'(bus_req), 64'd0);
        check("respack", 64'(bus_respack), 64'(bus_respvalid));
        hs = line_ok && ins_ready;
        if (sl_active && bus_respvalid) begin
            sl_beats++;
            if (sl_beats == 8) begin
                sl_active = 0;
                line_ok = !taint;
            end
        end
        if (bus_req && bus_reqack) begin
            check("req_addr", bus_reqaddr, exp_pc & LMASK);
            last_ack_addr = bus_reqaddr;
            sl_active = 1;
            sl_addr = exp_pc & LMASK;
            sl_beats = 0;
            taint = 0;
            gap_ctr = 0;
            last_line_hs = line_hs;
            line_hs = 0;
            ack_cnt++;
        end
        if (hs) begin
            hs_cnt++;
            line_hs++;
            exp_pc = exp_pc + 64'd4;
            if (exp_pc[5:0] == 6'd0) line_ok = 0;
        end
        if (redirect_valid) begin
            exp_pc = redirect_pc & ~64'h3;
            line_ok = 0;
            if (sl_active) taint = 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        observe();
        rst_prev2 = rst_prev;
        rst_prev = reset_n;
        fe_prev = fetch_en;
    endtask

    task automatic do_reset(input logic [63:0] pc);
        start_pc = pc;
        rst_cycles = 2;
        cycle();
        cycle();
    endtask

    task automatic wait_acks(input int n, input int lim);
        for (int i = 0; i < lim && ack_cnt < n; i++) cycle();
        check("tmo_acks", 64'(ack_cnt >= n), 64'd1);
    endtask

    initial begin
        int h;

        do_reset(64'h1000);
        wait_acks(2, 300);
        check("basic_cnt", 64'(last_line_hs), 64'd16);
        check("basic_next", last_ack_addr, 64'h1040);

        do_reset(64'h1018);
        wait_acks(1, 50);
        check("mid_first", last_ack_addr, 64'h1000);
        wait_acks(2, 300);
        check("mid_cnt", 64'(last_line_hs), 64'd10);
        check("mid_next", last_ack_addr, 64'h1040);

        gap_mode = 1;
        hold_armed = 1;
        do_reset(64'h1000);
        wait_acks(2, 600);
        check("bp_cnt", 64'(last_line_hs), 64'd16);
        check("bp_hold", 64'(hold_armed), 64'd0);
        gap_mode = 0;

        hook4 = 1;
        do_reset(64'h1000);
        wait_acks(2, 300);
        check("rd_hook", 64'(hook4), 64'd0);
        check("rd_addr", last_ack_addr, 64'h2000);
        h = hs_cnt;
        for (int i = 0; i < 100 && hs_cnt == h; i++) cycle();
        check("rd_issue", 64'(hs_cnt > h), 64'd1);

        hook5 = 1;
        do_reset(64'h1000);
        wait_acks(2, 300);
        check("rh_hook", 64'(hook5), 64'd0);
        check("rh_addr", last_ack_addr, 64'h3000);
        check("rh_cnt", 64'(last_line_hs), 64'd3);

        resp_pct = 50;
        hook6 = 1;
        do_reset(64'h1000);
        for (int i = 0; i < 300 && hook6; i++) cycle();
        check("rm_hook", 64'(hook6), 64'd0);
        cycle();
        cycle();
        for (int i = 0; i < 300 && !line_ok; i++) cycle();
        check("rm_issue", 64'(line_ok), 64'd1);
        check("rm_pc", last_ack_addr, 64'h1000);
        fe_pct = 0;
        for (int i = 0; i < 200 && busy; i++) cycle();
        check("rm_idle", 64'(busy), 64'd0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rm_noreq", 64'(bus_req), 64'd0);
        end

        fe_pct = 90;
        ack_pct = 60;
        resp_pct = 70;
        rdy_pct = 70;
        redir_pm = 20;
        do_reset(64'h1FFE);
        h = hs_cnt;
        for (int i = 0; i < 3000; i++) cycle();
        check("rand_live", 64'(hs_cnt - h > 50), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
